oflow_score_best_match: RTL and testbench

Downstream consumer of the similarity-metric stage. For one current-frame object it collects the stream of (score, id) results produced against every history object and keeps the lowest score as the best match. It then decides whether the object is a continuation of that history object or a new object, and allocates a fresh ID in the new-object case. The result is handed to the ID-assignment / history-update stage.

---
 rtl/oflow_score_best_match_pkg.sv | 14 +
 rtl/oflow_running_min.sv | 29 ++
 rtl/oflow_score_best_match.sv | 126 ++++++++++++
 tb/tb_oflow_score_best_match.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_score_best_match_pkg.sv
// rtl/oflow_score_best_match_pkg.sv - shared widths and FSM states for best-match selection
package oflow_score_best_match_pkg;

  localparam int SCORE_LEN = 32;
  localparam int ID_LEN    = 12;
  localparam int CAND_LEN  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2
  } state_t;

endpackage

// File: rtl/oflow_running_min.sv
// rtl/oflow_running_min.sv - running minimum of (score, id) pairs, earliest wins on ties
module oflow_running_min #(
  parameter int SCORE_LEN = 32,
  parameter int ID_LEN    = 12
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 clear,
  input  logic                 en,
  input  logic [SCORE_LEN-1:0] score,
  input  logic [ID_LEN-1:0]    id,
  output logic [SCORE_LEN-1:0] min,
  output logic [ID_LEN-1:0]    min_id
);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      min    <= '1;
      min_id <= '0;
    end else if (clear) begin
      min    <= '1;
      min_id <= '0;
    end else if (en && (score < min)) begin
      min    <= score;
      min_id <= id;
    end
  end

endmodule

// File: rtl/oflow_score_best_match.sv
// rtl/oflow_score_best_match.sv - picks the lowest-score history match and allocates fresh IDs
module oflow_score_best_match
  import oflow_score_best_match_pkg::*;
#(
  parameter int SCORE_LEN = oflow_score_best_match_pkg::SCORE_LEN,
  parameter int ID_LEN    = oflow_score_best_match_pkg::ID_LEN,
  parameter int CAND_LEN  = oflow_score_best_match_pkg::CAND_LEN
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start,
  input  logic [CAND_LEN-1:0]  num_of_candidates,
  input  logic [SCORE_LEN-1:0] score_threshold,
  input  logic                 score_valid,
  input  logic [SCORE_LEN-1:0] score,
  input  logic [ID_LEN-1:0]    id,
  output logic                 busy,
  output logic                 done,
  output logic [SCORE_LEN-1:0] best_score,
  output logic [ID_LEN-1:0]    best_id,
  output logic                 new_object,
  output logic [ID_LEN-1:0]    assigned_id
);

  state_t state, next_state;

  logic [CAND_LEN-1:0]  cand_left;
  logic [SCORE_LEN-1:0] thr_q;
  logic                 zero_q;
  logic [ID_LEN-1:0]    next_free_id;
  logic [SCORE_LEN-1:0] run_min;
  logic [ID_LEN-1:0]    run_id;
  logic [SCORE_LEN-1:0] best_score_q;
  logic [ID_LEN-1:0]    best_id_q;
  logic                 new_object_q;
  logic [ID_LEN-1:0]    assigned_id_q;
  logic                 accept;
  logic                 take;
  logic                 in_decide;
  logic                 decide_new;
  logic [ID_LEN-1:0]    decide_id;

  assign accept     = (state == IDLE) && start;
  assign take       = (state == COLLECT) && score_valid && (cand_left != '0);
  assign in_decide  = (state == DECIDE);
  assign decide_new = zero_q || (run_min > thr_q);
  assign decide_id  = decide_new ? next_free_id : run_id;

  oflow_running_min #(
    .SCORE_LEN (SCORE_LEN),
    .ID_LEN    (ID_LEN)
  ) u_running_min (
    .clk     (clk),
    .reset_N (reset_N),
    .clear   (accept),
    .en      (take),
    .score   (score),
    .id      (id),
    .min     (run_min),
    .min_id  (run_id)
  );

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= IDLE;
    else          state <= next_state;
  end

  // A zero-candidate search still spends one cycle in COLLECT so done lands two cycles after start.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (cand_left == '0)
          next_state = DECIDE;
        else if (score_valid && (cand_left == CAND_LEN'(1)))
          next_state = DECIDE;
      end
      DECIDE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cand_left     <= '0;
      thr_q         <= '0;
      zero_q        <= 1'b0;
      next_free_id  <= '0;
      best_score_q  <= '1;
      best_id_q     <= '0;
      new_object_q  <= 1'b0;
      assigned_id_q <= '0;
    end else begin
      if (accept) begin
        cand_left <= num_of_candidates;
        thr_q     <= score_threshold;
        zero_q    <= (num_of_candidates == '0);
      end else if (take) begin
        cand_left <= cand_left - CAND_LEN'(1);
      end
      if (in_decide) begin
        best_score_q  <= run_min;
        best_id_q     <= run_id;
        new_object_q  <= decide_new;
        assigned_id_q <= decide_id;
        if (decide_new) next_free_id <= next_free_id + ID_LEN'(1);
      end
    end
  end

  // During the done cycle the live decision is shown; the held copy takes over afterwards.
  assign best_score  = in_decide ? run_min    : best_score_q;
  assign best_id     = in_decide ? run_id     : best_id_q;
  assign new_object  = in_decide ? decide_new : new_object_q;
  assign assigned_id = in_decide ? decide_id  : assigned_id_q;

endmodule

// File: tb/tb_oflow_score_best_match.sv
// tb/tb_oflow_score_best_match.sv - directed self-checking bench for oflow_score_best_match
module tb_oflow_score_best_match;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        start;
  logic [6:0]  num_of_candidates;
  logic [31:0] score_threshold;
  logic        score_valid;
  logic [31:0] score;
  logic [11:0] id;
  logic        busy;
  logic        done;
  logic [31:0] best_score;
  logic [11:0] best_id;
  logic        new_object;
  logic [11:0] assigned_id;

  int errors = 0;
  int checks = 0;
  int nf     = 0;
  int done_seen;

  oflow_score_best_match dut (
    .clk               (clk),
    .reset_N           (reset_N),
    .start             (start),
    .num_of_candidates (num_of_candidates),
    .score_threshold   (score_threshold),
    .score_valid       (score_valid),
    .score             (score),
    .id                (id),
    .busy              (busy),
    .done              (done),
    .best_score        (best_score),
    .best_id           (best_id),
    .new_object        (new_object),
    .assigned_id       (assigned_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [6:0] n, input logic [31:0] thr);
    start = 1'b1;
    num_of_candidates = n;
    score_threshold = thr;
    step();
    start = 1'b0;
    num_of_candidates = 7'd0;
    score_threshold = 32'd0;
  endtask

  task automatic send(input logic [31:0] s, input logic [11:0] i);
    score_valid = 1'b1;
    score = s;
    id = i;
    step();
    score_valid = 1'b0;
    score = 32'd0;
    id = 12'd0;
  endtask

  initial begin
    reset_N = 1'b0;
    start = 1'b0;
    num_of_candidates = 7'd0;
    score_threshold = 32'd0;
    score_valid = 1'b0;
    score = 32'd0;
    id = 12'd0;
    step();
    step();

    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_done", 64'(done), 64'(1'b0));
    check("rst_best_score", 64'(best_score), 64'(32'hFFFF_FFFF));
    check("rst_best_id", 64'(best_id), 64'(12'd0));
    check("rst_new_object", 64'(new_object), 64'(1'b0));
    check("rst_assigned_id", 64'(assigned_id), 64'(12'd0));
    reset_N = 1'b1;
    step();

    // Run 1: back-to-back scores, tie on 20 keeps id 7
    begin_run(7'd4, 32'd100);
    check("r1_busy", 64'(busy), 64'(1'b1));
    send(32'd50, 12'd3);
    send(32'd20, 12'd7);
    send(32'd90, 12'd1);
    check("r1_no_early_done", 64'(done), 64'(1'b0));
    send(32'd20, 12'd9);
    check("r1_done", 64'(done), 64'(1'b1));
    check("r1_busy_low", 64'(busy), 64'(1'b0));
    check("r1_best_score", 64'(best_score), 64'(32'd20));
    check("r1_best_id", 64'(best_id), 64'(12'd7));
    check("r1_new_object", 64'(new_object), 64'(1'b0));
    check("r1_assigned_id", 64'(assigned_id), 64'(12'd7));
    step();
    check("r1_done_pulse", 64'(done), 64'(1'b0));
    check("r1_hold_score", 64'(best_score), 64'(32'd20));

    // Run 2: all above threshold, spaced pulses -> fresh ID 0
    begin_run(7'd3, 32'd10);
    send(32'd40, 12'd11);
    step();
    send(32'd25, 12'd12);
    step();
    step();
    send(32'd30, 12'd13);
    check("r2_done", 64'(done), 64'(1'b1));
    check("r2_best_score", 64'(best_score), 64'(32'd25));
    check("r2_best_id", 64'(best_id), 64'(12'd12));
    check("r2_new_object", 64'(new_object), 64'(1'b1));
    check("r2_assigned_id", 64'(assigned_id), 64'(nf));
    nf++;
    step();

    // Run 3: zero candidates, done two cycles after start
    begin_run(7'd0, 32'd500);
    check("r3_busy", 64'(busy), 64'(1'b1));
    check("r3_not_done_yet", 64'(done), 64'(1'b0));
    score_valid = 1'b1;
    score = 32'd1;
    id = 12'd55;
    step();
    score_valid = 1'b0;
    check("r3_done", 64'(done), 64'(1'b1));
    check("r3_new_object", 64'(new_object), 64'(1'b1));
    check("r3_best_score", 64'(best_score), 64'(32'hFFFF_FFFF));
    check("r3_best_id", 64'(best_id), 64'(12'd0));
    check("r3_assigned_id", 64'(assigned_id), 64'(nf));
    nf++;
    step();

    // Run 4: score equal to threshold is a match; start during COLLECT and on done is ignored
    begin_run(7'd1, 32'd100);
    begin_run(7'd0, 32'd0);
    check("r4_still_busy", 64'(busy), 64'(1'b1));
    send(32'd100, 12'd5);
    check("r4_done", 64'(done), 64'(1'b1));
    check("r4_new_object", 64'(new_object), 64'(1'b0));
    check("r4_best_score", 64'(best_score), 64'(32'd100));
    check("r4_assigned_id", 64'(assigned_id), 64'(12'd5));
    begin_run(7'd2, 32'd0);
    check("r4_start_on_done_ignored", 64'(busy), 64'(1'b0));
    check("r4_hold_assigned", 64'(assigned_id), 64'(12'd5));
    step();

    // Run 5: walk the fresh-ID counter up to 4095, then check the wrap to 0
    while (nf != 4095) begin
      begin_run(7'd0, 32'd0);
      step();
      step();
      nf++;
    end
    begin_run(7'd0, 32'd0);
    step();
    check("r5_done_4095", 64'(done), 64'(1'b1));
    check("r5_assigned_4095", 64'(assigned_id), 64'(12'd4095));
    step();
    begin_run(7'd0, 32'd0);
    step();
    check("r5_assigned_wrap", 64'(assigned_id), 64'(12'd0));
    nf = 1;
    step();

    // Run 6: asynchronous reset mid-collection, then a normal run
    begin_run(7'd5, 32'd50);
    send(32'd10, 12'd21);
    send(32'd11, 12'd22);
    #2;
    reset_N = 1'b0;
    #1;
    check("r6_busy_in_reset", 64'(busy), 64'(1'b0));
    check("r6_done_in_reset", 64'(done), 64'(1'b0));
    check("r6_score_in_reset", 64'(best_score), 64'(32'hFFFF_FFFF));
    step();
    reset_N = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      score_valid = (c < 3);
      score = 32'd5;
      id = 12'd30;
      step();
      if (done === 1'b1) done_seen++;
    end
    score_valid = 1'b0;
    check("r6_no_done_after_reset", 64'(done_seen), 64'(0));
    nf = 0;
    begin_run(7'd2, 32'd50);
    send(32'd60, 12'd1);
    send(32'd30, 12'd2);
    check("r6_done", 64'(done), 64'(1'b1));
    check("r6_best_score", 64'(best_score), 64'(32'd30));
    check("r6_best_id", 64'(best_id), 64'(12'd2));
    check("r6_new_object", 64'(new_object), 64'(1'b0));
    step();
    begin_run(7'd1, 32'd50);
    send(32'd70, 12'd3);
    check("r6_fresh_after_reset", 64'(assigned_id), 64'(nf));
    check("r6_new_after_reset", 64'(new_object), 64'(1'b1));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
